periph_irq_ctrl: RTL and testbench

PERIPH_IRQ_CTRL -- requirements
Module: periph_irq_ctrl

---
 rtl/periph_irq_ctrl.sv | 137 +++++++++++++
 tb/tb_periph_irq_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/periph_irq_ctrl.sv
// Peripheral interrupt controller: edge-latched pending bits, IDLE/REQ/SERVICE handshake, irq_o 2 edges after a source rise.
// Arbitration is fixed lowest-index priority; define IRQ_ROUND_ROBIN_EN to arbitrate round-robin from a rotating pointer.
module periph_irq_ctrl #(
  parameter int unsigned N_SRC = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_SRC-1:0]         src_irq_i,
  input  logic [N_SRC-1:0]         mie_i,
  input  logic                     irq_ack_i,
  input  logic                     irq_ret_i,
  output logic                     irq_o,
  output logic [$clog2(N_SRC)-1:0] irq_id_o,
  output logic [31:0]              irq_cause_o,
  output logic [N_SRC-1:0]         src_ack_o
);

  localparam int unsigned ID_W = $clog2(N_SRC);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t            state_q, state_d;
  logic [N_SRC-1:0]  src_prev_q;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  src_ack_q, src_ack_d;
  logic [N_SRC-1:0]  rise, cand, clr;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   win_id;
  logic              win_vld;
  logic              irq_q, irq_d;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0]   rr_q, rr_d;
`endif

  assign rise = src_irq_i & ~src_prev_q;
  assign cand = pending_q & mie_i;

`ifdef IRQ_ROUND_ROBIN_EN
  // Scan candidates starting at the pointer, wrapping at N_SRC.
  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] pos;
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    pos     = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      idx = (32'(rr_q) + k) % N_SRC;
      pos = ID_W'(idx);
      if (!win_vld && cand[pos]) begin
        win_vld = 1'b1;
        win_id  = pos;
      end
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!win_vld && cand[k]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    clr       = '0;
    src_ack_d = '0;
`ifdef IRQ_ROUND_ROBIN_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = REQ;
          id_d    = win_id;
        end
      end
      REQ: begin
        // Ack beats a same-cycle mask drop.
        if (irq_ack_i) begin
          state_d   = SERVICE;
          clr       = N_SRC'(1) << id_q;
          src_ack_d = N_SRC'(1) << id_q;
`ifdef IRQ_ROUND_ROBIN_EN
          rr_d      = (id_q == ID_W'(N_SRC - 1)) ? '0 : id_q + ID_W'(1);
`endif
        end else if (!mie_i[id_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (irq_ret_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new edge in the same cycle as the ack clear keeps the bit pending.
    pending_d = (pending_q & ~clr) | rise;
    irq_d     = (state_d == REQ);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      src_prev_q <= '0;
      pending_q  <= '0;
      src_ack_q  <= '0;
      id_q       <= '0;
      irq_q      <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
      rr_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      src_prev_q <= src_irq_i;
      pending_q  <= pending_d;
      src_ack_q  <= src_ack_d;
      id_q       <= id_d;
      irq_q      <= irq_d;
`ifdef IRQ_ROUND_ROBIN_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign irq_o       = irq_q;
  assign irq_id_o    = id_q;
  assign irq_cause_o = 32'h8000_0010 + 32'(id_q);
  assign src_ack_o   = src_ack_q;

endmodule

// File: tb/tb_periph_irq_ctrl.sv
// Directed bench for periph_irq_ctrl (N_SRC=4); outputs checked 1 time unit after each rising edge.
module tb_periph_irq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  src_irq_i;
  logic [3:0]  mie_i;
  logic        irq_ack_i;
  logic        irq_ret_i;
  logic        irq_o;
  logic [1:0]  irq_id_o;
  logic [31:0] irq_cause_o;
  logic [3:0]  src_ack_o;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef IRQ_ROUND_ROBIN_EN
  localparam logic [1:0] FIRST  = 2'd3;
  localparam logic [1:0] SECOND = 2'd1;
`else
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] SECOND = 2'd3;
`endif

  periph_irq_ctrl #(.N_SRC(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .src_irq_i   (src_irq_i),
    .mie_i       (mie_i),
    .irq_ack_i   (irq_ack_i),
    .irq_ret_i   (irq_ret_i),
    .irq_o       (irq_o),
    .irq_id_o    (irq_id_o),
    .irq_cause_o (irq_cause_o),
    .src_ack_o   (src_ack_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic e_irq, input logic [1:0] e_id,
                     input logic [3:0] e_ack, input bit chk_id);
    logic [31:0] e_cause;
    e_cause = 32'h8000_0010 + {30'd0, e_id};
    n_chk++;
    assert (irq_o === e_irq) else begin
      n_fail++;
      $error("FAIL %s irq_o: observed %0b expected %0b", tag, irq_o, e_irq);
    end
    n_chk++;
    assert (src_ack_o === e_ack) else begin
      n_fail++;
      $error("FAIL %s src_ack_o: observed %b expected %b", tag, src_ack_o, e_ack);
    end
    if (chk_id) begin
      n_chk++;
      assert (irq_id_o === e_id) else begin
        n_fail++;
        $error("FAIL %s irq_id_o: observed %0d expected %0d", tag, irq_id_o, e_id);
      end
      n_chk++;
      assert (irq_cause_o === e_cause) else begin
        n_fail++;
        $error("FAIL %s irq_cause_o: observed %h expected %h", tag, irq_cause_o, e_cause);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; src_irq_i = '0; mie_i = '0; irq_ack_i = 1'b0; irq_ret_i = 1'b0;
    tick();
    chk("reset", 1'b0, 2'd0, 4'b0000, 1'b1);
    rst_i = 1'b0;

    // Single source, full latency and ack pulse.
    mie_i = 4'b1111; src_irq_i = 4'b0100;
    tick(); chk("s1_pend", 1'b0, 2'd0, 4'b0000, 1'b1);
    src_irq_i = '0;
    tick(); chk("s1_req", 1'b1, 2'd2, 4'b0000, 1'b1);
    irq_ack_i = 1'b1;
    tick(); chk("s1_ack", 1'b0, 2'd2, 4'b0100, 1'b1);
    irq_ack_i = 1'b0;
    tick(); chk("s1_ack_end", 1'b0, 2'd2, 4'b0000, 1'b1);
    irq_ack_i = 1'b1;
    tick(); chk("s1_ack_ign", 1'b0, 2'd2, 4'b0000, 1'b1);
    irq_ack_i = 1'b0; irq_ret_i = 1'b1;
    tick(); chk("s1_ret", 1'b0, 2'd0, 4'b0000, 1'b0);
    irq_ret_i = 1'b0;
    tick(); chk("s1_idle", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Two simultaneous sources: arbitration order.
    src_irq_i = 4'b1010;
    tick(); chk("s2_pend", 1'b0, 2'd0, 4'b0000, 1'b0);
    src_irq_i = '0;
    tick(); chk("s2_req1", 1'b1, FIRST, 4'b0000, 1'b1);
    irq_ack_i = 1'b1;
    tick(); chk("s2_ack1", 1'b0, FIRST, 4'b0001 << FIRST, 1'b1);
    irq_ack_i = 1'b0; irq_ret_i = 1'b1;
    tick(); chk("s2_ret1", 1'b0, 2'd0, 4'b0000, 1'b0);
    irq_ret_i = 1'b0;
    tick(); chk("s2_req2", 1'b1, SECOND, 4'b0000, 1'b1);
    irq_ack_i = 1'b1;
    tick(); chk("s2_ack2", 1'b0, SECOND, 4'b0001 << SECOND, 1'b1);
    irq_ack_i = 1'b0; irq_ret_i = 1'b1;
    tick(); irq_ret_i = 1'b0;

    // Masked pending is retained until enabled.
    mie_i = 4'b0000; src_irq_i = 4'b0001;
    tick(); src_irq_i = '0;
    tick(); chk("s3_masked", 1'b0, 2'd0, 4'b0000, 1'b0);
    tick(); chk("s3_masked2", 1'b0, 2'd0, 4'b0000, 1'b0);
    mie_i = 4'b0001;
    tick(); chk("s3_unmask", 1'b1, 2'd0, 4'b0000, 1'b1);
    irq_ack_i = 1'b1;
    tick(); chk("s3_ack", 1'b0, 2'd0, 4'b0001, 1'b1);
    irq_ack_i = 1'b0; irq_ret_i = 1'b1;
    tick(); irq_ret_i = 1'b0;

    // Mask drop in REQ, then ack priority over a mask drop.
    mie_i = 4'b1111; src_irq_i = 4'b0010;
    tick(); src_irq_i = '0;
    tick(); chk("s4_req", 1'b1, 2'd1, 4'b0000, 1'b1);
    mie_i = 4'b1101;
    tick(); chk("s4_drop", 1'b0, 2'd0, 4'b0000, 1'b0);
    tick(); chk("s4_hold", 1'b0, 2'd0, 4'b0000, 1'b0);
    mie_i = 4'b1111;
    tick(); chk("s4_rereq", 1'b1, 2'd1, 4'b0000, 1'b1);
    irq_ack_i = 1'b1; mie_i = 4'b1101;
    tick(); chk("s4_ack_prio", 1'b0, 2'd1, 4'b0010, 1'b1);
    irq_ack_i = 1'b0; mie_i = 4'b1111;
    tick(); chk("s4_svc", 1'b0, 2'd1, 4'b0000, 1'b1);
    irq_ret_i = 1'b1;
    tick(); tick();
    irq_ret_i = 1'b0;
    chk("s4_ret_idle", 1'b0, 2'd0, 4'b0000, 1'b0);

    // ret ignored in REQ; no nesting during SERVICE; one idle cycle before re-arbitration.
    src_irq_i = 4'b0010;
    tick(); src_irq_i = '0;
    tick(); irq_ret_i = 1'b1;
    tick(); irq_ret_i = 1'b0;
    chk("s5_ret_ign", 1'b1, 2'd1, 4'b0000, 1'b1);
    irq_ack_i = 1'b1;
    tick(); irq_ack_i = 1'b0;
    chk("s5_ack", 1'b0, 2'd1, 4'b0010, 1'b1);
    src_irq_i = 4'b0001;
    tick(); chk("s5_no_nest", 1'b0, 2'd1, 4'b0000, 1'b1);
    src_irq_i = '0;
    tick(); chk("s5_no_nest2", 1'b0, 2'd1, 4'b0000, 1'b1);
    irq_ret_i = 1'b1;
    tick(); irq_ret_i = 1'b0;
    chk("s5_idle", 1'b0, 2'd0, 4'b0000, 1'b0);
    tick(); chk("s5_req0", 1'b1, 2'd0, 4'b0000, 1'b1);

    // New edge coincident with the ack clear keeps the source pending.
    src_irq_i = 4'b0001; irq_ack_i = 1'b1;
    tick(); src_irq_i = '0; irq_ack_i = 1'b0;
    chk("s6_ack", 1'b0, 2'd0, 4'b0001, 1'b1);
    irq_ret_i = 1'b1;
    tick(); irq_ret_i = 1'b0;
    chk("s6_idle", 1'b0, 2'd0, 4'b0000, 1'b0);
    tick(); chk("s6_set_wins", 1'b1, 2'd0, 4'b0000, 1'b1);
    irq_ack_i = 1'b1;
    tick(); irq_ack_i = 1'b0; irq_ret_i = 1'b1;
    tick(); irq_ret_i = 1'b0;

    // Reset during SERVICE with src_ack high and another source pending.
    src_irq_i = 4'b0100;
    tick(); src_irq_i = '0;
    tick(); chk("s7_req", 1'b1, 2'd2, 4'b0000, 1'b1);
    irq_ack_i = 1'b1; src_irq_i = 4'b1000;
    tick(); irq_ack_i = 1'b0; src_irq_i = '0;
    chk("s7_svc", 1'b0, 2'd2, 4'b0100, 1'b1);
    rst_i = 1'b1;
    #1 chk("s7_rst_async", 1'b0, 2'd0, 4'b0000, 1'b1);
    tick(); rst_i = 1'b0;
    tick(); chk("s7_no_pend", 1'b0, 2'd0, 4'b0000, 1'b1);
    tick(); chk("s7_no_pend2", 1'b0, 2'd0, 4'b0000, 1'b1);

    // Source held high through reset release counts as an edge at the first clock.
    rst_i = 1'b1; src_irq_i = 4'b0001;
    tick(); rst_i = 1'b0;
    tick(); chk("s8_first", 1'b0, 2'd0, 4'b0000, 1'b1);
    tick(); chk("s8_req", 1'b1, 2'd0, 4'b0000, 1'b1);
    src_irq_i = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
